// File: rtl/cmp_scan_display_pkg.sv
// Shared types and constants for the serial comparator / seven-segment scanner.
package cmp_scan_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    // Index width for a digit counter; a single bit is kept even for tiny counts.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cmp_scan_display_if.sv
// Operand/load side and display/result side of the comparator, bundled as one bus.
interface cmp_scan_display_if #(
    parameter int DIGITS = 4
);
    import cmp_scan_pkg::*;

    logic                        load;
    logic                        sel_b;
    logic [DIGIT_W*DIGITS-1:0]   din_a;
    logic [DIGIT_W*DIGITS-1:0]   din_b;
    logic [6:0]                  dout_seg;
    logic                        dout_dp;
    logic [DIGITS-1:0]           dout_an;
    logic                        dout_gt;
    logic                        dout_lt;
    logic                        dout_eq;
    logic                        busy;
    logic                        done;

    modport master (
        output load, sel_b, din_a, din_b,
        input  dout_seg, dout_dp, dout_an, dout_gt, dout_lt, dout_eq, busy, done
    );

    modport slave (
        input  load, sel_b, din_a, din_b,
        output dout_seg, dout_dp, dout_an, dout_gt, dout_lt, dout_eq, busy, done
    );

endinterface

// File: rtl/cmp_scan_display_sevenseg.sv
// Hex digit to active-high segment pattern, bit order {g,f,e,d,c,b,a}.
module cmp_scan_display_sevenseg
    import cmp_scan_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [6:0]         seg
);

    always_comb begin
        seg = 7'h00;
        case (digit)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/cmp_scan_display.sv
// N-digit serial MSB-first magnitude comparator with a free-running multiplexed
// seven-segment readout of the captured operands.
module cmp_scan_display
    import cmp_scan_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000
) (
    input  logic                clk,
    input  logic                rst,
    cmp_scan_display_if.slave   bus
);

    localparam int IW = idx_w(DIGITS);
    localparam int PW = (DIV <= 1) ? 1 : $clog2(DIV);
    localparam int OW = DIGIT_W * DIGITS;

    state_t            state_q, state_d;
    logic [OW-1:0]     a_q, a_d, b_q, b_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     scan_q, scan_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic              gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;

    logic [DIGIT_W-1:0] a_dig [DIGITS];
    logic [DIGIT_W-1:0] b_dig [DIGITS];
    logic [DIGIT_W-1:0] disp_dig;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digits
            assign a_dig[gi]        = a_q[DIGIT_W*gi +: DIGIT_W];
            assign b_dig[gi]        = b_q[DIGIT_W*gi +: DIGIT_W];
            assign bus.dout_an[gi]  = (scan_q == IW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            scan_q  <= '0;
            pre_q   <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            scan_q  <= scan_d;
            pre_q   <= pre_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    // Compare walks down from the MSB digit and stops at the first difference.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    a_d     = bus.din_a;
                    b_d     = bus.din_b;
                    idx_d   = IW'(DIGITS - 1);
                    state_d = CMP;
                end
            end
            CMP: begin
                if (a_dig[idx_q] != b_dig[idx_q]) begin
                    gt_d    = (a_dig[idx_q] > b_dig[idx_q]);
                    lt_d    = (a_dig[idx_q] < b_dig[idx_q]);
                    eq_d    = 1'b0;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pre_d  = pre_q + 1'b1;
        scan_d = scan_q;
        if (pre_q == PW'(DIV - 1)) begin
            pre_d  = '0;
            scan_d = (scan_q == IW'(DIGITS - 1)) ? '0 : scan_q + 1'b1;
        end
    end

    assign disp_dig    = bus.sel_b ? b_dig[scan_q] : a_dig[scan_q];
    assign bus.dout_dp = (gt_q && (scan_q == IW'(DIGITS - 1))) || (lt_q && (scan_q == '0));
    assign bus.dout_gt = gt_q;
    assign bus.dout_lt = lt_q;
    assign bus.dout_eq = eq_q;
    assign bus.busy    = (state_q == CMP);
    assign bus.done    = (state_q == DONE);

    cmp_scan_display_sevenseg u_seg (
        .digit (disp_dig),
        .seg   (bus.dout_seg)
    );

endmodule
